// File: rtl/mips_pkg.sv
// mips_pkg: constants, FSM state type and helpers shared by the fetch unit.
// Provides XLEN, the default reset PC, the buffer entry width and the PC increment.
package mips_pkg;
  localparam int XLEN = 32;
  localparam int FIFO_W = 2 * XLEN;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_e;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: 2-entry buffer of {instruction, pc} between fetch and decode.
// Ports: clk, i_rst, i_flush, i_push/i_data, i_pop, o_head, o_full, o_empty.
module ifu_fifo
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [FIFO_W-1:0] i_data,
  input  logic              i_pop,
  output logic [FIFO_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);
  logic [FIFO_W-1:0] r_mem [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wp] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/ifu.sv
// ifu: fetch unit; one outstanding imem request, 2-entry buffer toward decode.
// Ports: clk/rst, redirect, imem req/resp, ins handshake, addr_err. Option: IFU_ALIGN_CHECK_EN.
module ifu
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_pc,
  output logic            addr_err
);
  ifu_state_e        r_state;
  logic [XLEN-1:0]   r_fpc;
  logic [XLEN-1:0]   r_req_pc;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_err;
  logic              w_tgt_ok;
  logic [XLEN-1:0]   w_tgt;
  logic [FIFO_W-1:0] w_head;

  assign w_tgt = redirect_pc & ALIGN_MASK;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_addr_err;

  assign w_tgt_ok = (redirect_pc[1:0] == 2'b00);
  assign w_err    = r_addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (redirect_valid && !w_tgt_ok) begin
      r_addr_err <= 1'b1;
    end
  end
`else
  assign w_tgt_ok = 1'b1;
  assign w_err    = 1'b0;
`endif

  assign addr_err  = w_err;
  assign imem_addr = r_fpc;

  assign imem_req_valid = !rst && (r_state == IDLE) && !w_full
                          && !redirect_valid && !w_err;
  assign w_accept = imem_req_valid && imem_req_ready;

  // A redirect kills both the in-flight response and the head pop.
  assign w_push = (r_state == WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pop  = ins_valid && ins_ready && !redirect_valid;

  assign ins_valid = !rst && !w_empty;
  assign ins       = ins_valid ? w_head[FIFO_W-1:XLEN] : '0;
  assign ins_pc    = ins_valid ? w_head[XLEN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fpc    <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        if (w_tgt_ok) r_fpc <= w_tgt;
      end else if (w_accept) begin
        r_fpc    <= pc_inc(r_fpc);
        r_req_pc <= r_fpc;
      end
      unique case (r_state)
        IDLE: if (w_accept) r_state <= WAIT;
        WAIT: begin
          if (imem_resp_valid) r_state <= IDLE;
          else if (redirect_valid) r_state <= DROP;
        end
        DROP: if (imem_resp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  ifu_fifo u_fifo (
    .clk     (clk),
    .i_rst   (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  ({imem_resp_data, r_req_pc}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed vector table, hand corner sequences and a randomized run
// checked against a program-order model of fetch and delivery.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        addr_err;

  always #5 clk = ~clk;

  ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .ins_valid       (ins_valid),
    .ins_ready       (ins_ready),
    .ins             (ins),
    .ins_pc          (ins_pc),
    .addr_err        (addr_err)
  );

  // c = {rst, redirect, req_ready, resp_valid, ins_ready}; ef = {req_valid, ins_valid, addr_err}
  typedef struct {
    logic [4:0]  c;
    logic [31:0] rpc;
    logic [31:0] rsp_pc;
    logic [2:0]  ef;
    logic [31:0] ea;
    logic [31:0] eipc;
  } vec_t;

  vec_t tv[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic [4:0] c, input logic [31:0] rpc, input logic [31:0] rpa,
                     input logic [2:0] ef, input logic [31:0] ea, input logic [31:0] eipc);
    tv.push_back('{c, rpc, rpa, ef, ea, eipc});
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] rpc, input logic [31:0] rpa);
    @(negedge clk);
    rst             = c[4];
    redirect_valid  = c[3];
    redirect_pc     = rpc;
    imem_req_ready  = c[2];
    imem_resp_valid = c[1];
    imem_resp_data  = c[1] ? memf(rpa) : 32'h0;
    ins_ready       = c[0];
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend;
    int          lat;
    logic [31:0] maddr;
    logic [31:0] epc;
    logic [31:0] efetch;
    logic [31:0] rp;
    logic        hold;
    logic [31:0] hold_pc;
    int          ndel;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    ins_ready = 1'b1;

    add(5'b10101, 32'h0, 32'h0, 3'b000, 32'h3000, 32'h0);
    add(5'b00101, 32'h0, 32'h0, 3'b100, 32'h3000, 32'h0);
    add(5'b00111, 32'h0, 32'h3000, 3'b000, 32'h3004, 32'h0);
    add(5'b00101, 32'h0, 32'h0, 3'b110, 32'h3004, 32'h3000);
    add(5'b00111, 32'h0, 32'h3004, 3'b000, 32'h3008, 32'h0);
    add(5'b00101, 32'h0, 32'h0, 3'b110, 32'h3008, 32'h3004);
    add(5'b00111, 32'h0, 32'h3008, 3'b000, 32'h300C, 32'h0);
    add(5'b00100, 32'h0, 32'h0, 3'b110, 32'h300C, 32'h3008);
    add(5'b00110, 32'h0, 32'h300C, 3'b010, 32'h3010, 32'h3008);
    add(5'b00100, 32'h0, 32'h0, 3'b010, 32'h3010, 32'h3008);
    add(5'b00101, 32'h0, 32'h0, 3'b010, 32'h3010, 32'h3008);
    add(5'b00100, 32'h0, 32'h0, 3'b110, 32'h3010, 32'h300C);
    add(5'b01101, 32'h4000, 32'h0, 3'b010, 32'h3014, 32'h300C);
    add(5'b00111, 32'h0, 32'h3010, 3'b000, 32'h4000, 32'h0);
    add(5'b00101, 32'h0, 32'h0, 3'b100, 32'h4000, 32'h0);
    add(5'b00111, 32'h0, 32'h4000, 3'b000, 32'h4004, 32'h0);
    add(5'b00100, 32'h0, 32'h0, 3'b110, 32'h4004, 32'h4000);
    add(5'b01111, 32'h5000, 32'h4004, 3'b010, 32'h4008, 32'h4000);
    add(5'b00001, 32'h0, 32'h0, 3'b100, 32'h5000, 32'h0);
    add(5'b00101, 32'h0, 32'h0, 3'b100, 32'h5000, 32'h0);
    add(5'b01101, 32'h4002, 32'h0, 3'b000, 32'h5004, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
    add(5'b00111, 32'h0, 32'h5000, 3'b001, 32'h5004, 32'h0);
    add(5'b00001, 32'h0, 32'h0, 3'b001, 32'h5004, 32'h0);
`else
    add(5'b00111, 32'h0, 32'h5000, 3'b000, 32'h4000, 32'h0);
    add(5'b00001, 32'h0, 32'h0, 3'b100, 32'h4000, 32'h0);
`endif

    drive(5'b10101, 32'h0, 32'h0);
    drive(5'b10101, 32'h0, 32'h0);
    foreach (tv[i]) begin
      drive(tv[i].c, tv[i].rpc, tv[i].rsp_pc);
      chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(tv[i].ef[2]));
      chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].ea);
      chk($sformatf("v%0d ins_valid", i), 32'(ins_valid), 32'(tv[i].ef[1]));
      chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(tv[i].ef[0]));
      if (tv[i].ef[1] || tv[i].c[4]) begin
        chk($sformatf("v%0d ins_pc", i), ins_pc, tv[i].ef[1] ? tv[i].eipc : 32'h0);
        chk($sformatf("v%0d ins", i), ins, tv[i].ef[1] ? memf(tv[i].eipc) : 32'h0);
      end
    end

    // PC wrap past the top of the address space, then a reset mid-request.
    drive(5'b10101, 32'h0, 32'h0);
    drive(5'b10101, 32'h0, 32'h0);
    drive(5'b01101, 32'hFFFF_FFFC, 32'h0);
    chk("redir_block", 32'(imem_req_valid), 32'h0);
    drive(5'b00101, 32'h0, 32'h0);
    chk("top_req", 32'(imem_req_valid), 32'h1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    drive(5'b00111, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    drive(5'b00101, 32'h0, 32'h0);
    chk("wrap_req", 32'(imem_req_valid), 32'h1);
    chk("wrap_req_addr", imem_addr, 32'h0);
    chk("top_ins_pc", ins_pc, 32'hFFFF_FFFC);
    chk("top_ins", ins, memf(32'hFFFF_FFFC));
    drive(5'b10101, 32'h0, 32'h0);
    chk("rst_req", 32'(imem_req_valid), 32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    drive(5'b00010, 32'h0, 32'h0);
    chk("post_rst_req", 32'(imem_req_valid), 32'h1);
    chk("post_rst_addr", imem_addr, 32'h3000);
    drive(5'b00000, 32'h0, 32'h0);
    chk("rst_drop", 32'(ins_valid), 32'h0);

    // Randomized run against a program-order model.
    drive(5'b10101, 32'h0, 32'h0);
    drive(5'b10101, 32'h0, 32'h0);
    pend = 1'b0; lat = 0; maddr = 32'h0;
    epc = 32'h3000; efetch = 32'h3000;
    hold = 1'b0; hold_pc = 32'h0; ndel = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      redirect_valid = ($urandom_range(0, 11) == 0);
      rp = 32'h0000_8000 + ($urandom_range(0, 63) << 2);
`ifndef IFU_ALIGN_CHECK_EN
      rp = rp | $urandom_range(0, 3);
`endif
      redirect_pc = rp;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      ins_ready = ($urandom_range(0, 2) != 0);
      imem_resp_valid = pend && (lat == 0);
      imem_resp_data = imem_resp_valid ? memf(maddr) : $urandom();
      #1;
      chk("req_gate", 32'(imem_req_valid && (pend || redirect_valid)), 32'h0);
      if (hold) chk("hold_pc", ins_pc, hold_pc);
      if (imem_resp_valid) pend = 1'b0;
      else if (pend) lat--;
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_fetch", imem_addr, efetch);
        pend = 1'b1;
        lat = $urandom_range(0, 3);
        maddr = imem_addr;
        efetch = efetch + 32'd4;
      end
      if (ins_valid && ins_ready && !redirect_valid) begin
        chk("rnd_ins_pc", ins_pc, epc);
        chk("rnd_ins", ins, memf(epc));
        epc = epc + 32'd4;
        ndel++;
      end
      if (redirect_valid) begin
        epc = rp & ~32'h3;
        efetch = epc;
      end
      hold = ins_valid && !ins_ready && !redirect_valid;
      hold_pc = ins_pc;
    end
    chk("progress", 32'(ndel > 100), 32'h1);
    chk("err_clear", 32'(addr_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000, giving the first fetch address after reset.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL provide port redirect_valid, input, 1 bit: a taken branch or jump target is presented this cycle.
REQ-005 SHALL provide port redirect_pc, input, 32 bits: new fetch address from the next-PC logic.
REQ-006 SHALL provide port imem_req_valid, output, 1 bit: fetch request valid.
REQ-007 SHALL provide port imem_req_ready, input, 1 bit: instruction memory accepts the request.
REQ-008 SHALL provide port imem_addr, output, 32 bits: word address of the request.
REQ-009 SHALL provide port imem_resp_valid, input, 1 bit: read data is valid this cycle; responses return in request order.
REQ-010 SHALL provide port imem_resp_data, input, 32 bits: instruction word.
REQ-011 SHALL provide port ins_valid, output, 1 bit: the instruction is valid toward decode.
REQ-012 SHALL provide port ins_ready, input, 1 bit: decode accepts the instruction.
REQ-013 SHALL provide ports ins and ins_pc, outputs, 32 bits each: the instruction word and its address.
REQ-014 SHALL provide port addr_err, output, 1 bit: sticky misaligned-redirect flag.

Function
REQ-015 SHALL hold the fetch PC register fpc; imem_addr SHALL equal fpc.
REQ-016 SHALL keep at most one request outstanding; a request is accepted when imem_req_valid and imem_req_ready are both high in the same cycle.
REQ-017 SHALL assert imem_req_valid only when no request is outstanding, buffer occupancy is below 2, no redirect is present, and addr_err is 0.
REQ-018 SHALL advance fpc to fpc+4 on request acceptance, with the sum wrapping modulo 2^32.
REQ-019 SHALL implement FSM states IDLE (issuing allowed), WAIT (one request outstanding), and DROP (the outstanding response is to be discarded).
REQ-020 SHALL take these transitions: IDLE->WAIT on acceptance; WAIT->IDLE on imem_resp_valid; WAIT->DROP on redirect; DROP->IDLE on imem_resp_valid.
REQ-021 SHALL push {resp_data, request address} into a 2-entry FIFO on a response received in WAIT; a response received in DROP SHALL be discarded.
REQ-022 SHALL drive ins_valid = FIFO not empty, and ins/ins_pc = the FIFO head; the FIFO SHALL pop on ins_valid && ins_ready.
REQ-023 SHALL apply the following on redirect_valid: flush the FIFO, load fpc with redirect_pc, and suppress request issue that cycle.
REQ-024 SHALL give redirect priority over a simultaneous push or pop, and over acceptance, which is blocked by REQ-017.
REQ-025 SHALL, on a redirect arriving in the same cycle as imem_resp_valid in WAIT, discard the response and go to IDLE.
REQ-026 SHALL allow a push and a pop in the same cycle when the FIFO holds 1 entry, leaving the count unchanged.
REQ-027 SHALL, when the FIFO is full, hold ins/ins_pc stable while ins_ready is low and issue no request.
REQ-028 SHALL deliver the first instruction with ins_valid high no earlier than 1 cycle after imem_resp_valid.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set fpc=RESET_PC, state=IDLE, FIFO empty, and addr_err=0.
REQ-030 SHALL hold ins_valid=0, imem_req_valid=0, and ins=ins_pc=0 during reset, so the first request appears in the cycle after rst falls.
REQ-031 SHALL discard any response arriving after a mid-operation reset, until a new request is accepted.

Configuration
REQ-032 SHALL, with IFU_ALIGN_CHECK_EN defined, set addr_err on a redirect whose redirect_pc[1:0] != 2'b00, and leave fpc unchanged on that redirect.
REQ-033 SHALL, with IFU_ALIGN_CHECK_EN defined, keep addr_err set until reset and halt issue while it is set.
REQ-034 SHALL, without IFU_ALIGN_CHECK_EN, force redirect_pc[1:0] to 2'b00 when loading fpc, and tie addr_err to 0.

Structure
REQ-035 SHALL take the XLEN=32 constant, the RESET_PC default, and the FSM state enum from shared package mips_pkg.
REQ-036 SHALL implement the 2-entry buffer as sub-module ifu_fifo (64-bit entries; push/pop/flush; full/empty outputs).

Verification
REQ-037 SHALL cover reset release with imem_req_ready=1, 1-cycle response latency, and ins_ready=1: imem_addr sequence 0x3000, 0x3004, 0x3008, with ins_pc following the same sequence.
REQ-038 SHALL cover ins_ready=0 for 10 cycles: the FIFO fills with 0x3000/0x3004, imem_req_valid drops, and ins stays stable; on release, pops occur in order with no loss.
REQ-039 SHALL cover redirect to 0x4000 while in WAIT: the late response is dropped, the next delivered ins_pc is 0x4000, and 0x3004 never appears.
REQ-040 SHALL cover a redirect in the same cycle as imem_resp_valid and a pop: the FIFO ends empty and the next request address is the redirect target.
REQ-041 SHALL cover redirect_pc=0x4002: with the macro, addr_err=1 and no further requests; without the macro, the next fetch address is 0x4000.
REQ-042 SHALL cover fpc=0xFFFF_FFFC: the next request address is 0x0000_0000.
